rc4_key_search_ctrl: RTL
========================

# rc4_key_search_ctrl

Sequencing controller and s_memory port owner for the RC4 key-search datapath. Per candidate key it launches the three phase FSMs in order: init (S[i]=i), shuffle, decrypt. Only the phase currently running gets the single port of s_memory. On a decrypt failure it advances the key and repeats, and it stops on success, exhaustion, watchdog timeout or abort. It replaces the ad-hoc done-flag mux and per-phase reset pulses in the top level.

## Interface
- `KEY_W`, default 24: candidate key width.
- `KEY_MAX`, default 24'h3FFFFF: last key searched (inclusive).
- `ADDR_W`, default 8: s_memory address width.
- `DATA_W`, default 8: s_memory data width.
- `TIMEOUT_CYC`, default 4095: maximum cycles any phase may stay in RUN.

- `clk`  in  1  system clock (CLOCK_50); sole clock.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  begin a search at `key_start`; honoured only in IDLE, DONE_OK, DONE_EXH or DONE_ERR.
- `abort`  in  1  return to IDLE on the next edge.
- `key_start`  in  KEY_W  first key; latched on an accepted `start`.
- `init_done`, `shuf_done`, `dec_done`  in  1  phase-complete pulses.
- `dec_fail`  in  1  decrypt found a non-printable byte.
- `init_go`, `shuf_go`, `dec_go`  out  1  one-cycle phase launch pulses.
- `init_addr`/`init_data`/`init_wren`, `shuf_addr`/`shuf_data`/`shuf_wren`, `dec_addr`/`dec_data`/`dec_wren`  in  ADDR_W/DATA_W/1  requester ports.
- `mem_addr`, `mem_data`, `mem_wren`  out  ADDR_W, DATA_W, 1  to s_memory.
- `key`  out  KEY_W  current candidate key.
- `busy`, `found`, `exhausted`, `error`  out  1  status flags.

## Operation
- States: IDLE, INIT_GO, INIT_RUN, SHUF_GO, SHUF_RUN, DEC_GO, DEC_RUN, NEXT_KEY, DONE_OK, DONE_EXH, DONE_ERR.
- Accepted `start`: latch `key <= key_start` and go to INIT_GO.
- GO states: assert the matching `*_go` for exactly one cycle, then enter the matching RUN state.
- INIT_RUN + `init_done` → SHUF_GO.
- SHUF_RUN + `shuf_done` → DEC_GO.
- DEC_RUN + `dec_done` without `dec_fail` → DONE_OK.
- DEC_RUN + `dec_fail` → NEXT_KEY. `dec_fail` wins over a simultaneous `dec_done`.
- NEXT_KEY:
  - `key == KEY_MAX` → DONE_EXH, with `key` held.
  - Otherwise `key <= key+1` → INIT_GO.
- Done or fail pulses arriving in any state other than the matching RUN are ignored.
- Owner register: INIT, SHUF, DEC or NONE.
  - Equals the phase in its GO and RUN states; NONE everywhere else.
  - Changes only on a state transition.
- Port mux, combinational from the owner register:
  - Selected requester drives `mem_addr`/`mem_data`/`mem_wren`.
  - NONE drives address 0, data 0, `wren` 0.
  - `wren` from a non-owner never reaches memory.
- Watchdog: 12-bit phase counter, cleared in every GO state, incremented in RUN. When it reaches `TIMEOUT_CYC` in RUN → DONE_ERR.
- `abort` from any state → IDLE with owner NONE. `key` holds its value.
- `rst` has priority over `abort` and `start`.
- Status flags:
  - `busy` = not in IDLE or any DONE state.
  - `found`, `exhausted` and `error` are each high only in their DONE state.

## Timing
- Reset values:
  - State IDLE, owner NONE, `key` 0, counter 0.
  - All `*_go`, `mem_wren`, `busy`, `found`, `exhausted`, `error` = 0.
  - `mem_addr` and `mem_data` = 0.
- `start` in cycle N → `init_go` and `busy` high in N+1, owner INIT from N+1.
- Done pulse in cycle N → the next phase's `*_go` in N+1, and ownership switches at the N+1 edge. There is no cycle in which two requesters can write.
- Key advance: `dec_fail` in N → NEXT_KEY in N+1 → `init_go` with the new `key` in N+2.
- Mux adds zero latency: `mem_*` follow the requester in the same cycle.
- Outputs are registered except the `mem_*` mux.

## Structure
- Package `rc4_ctrl_pkg`:
  - `state_t` and `owner_t` enums.
  - Default `KEY_MAX`, `TIMEOUT_CYC` and the key width.
  - Shared by the phase FSMs and the top level.
- Sub-module `s_mem_port_mux`: purely combinational three-way plus NONE mux, indexed by `owner_t`. Everything else lives in this module.

## Test plan
- `start` with `key_start`=0x000249, phase stubs return done after 10 cycles and no fail:
  - Go pulses appear in order init, shuf, dec, each one cycle.
  - `found`=1, `key`=0x000249, `busy`=0.
- Stub fails the first 3 keys from 0x000010:
  - `key` steps 0x10, 0x11, 0x12, 0x13.
  - `found` with `key`=0x000013.
  - `init_go` fires two cycles after each `dec_fail`.
- `key_start`=KEY_MAX with `dec_fail` → `exhausted`=1, `key`=0x3FFFFF, no further go pulses.
- All requesters assert `wren` with distinct addresses (0x11, 0x22, 0x33):
  - `mem_addr` tracks only the owner in each phase.
  - `mem_wren`=0 in IDLE, NEXT_KEY and DONE states.
- Shuffle stub never signals done → `error`=1 exactly `TIMEOUT_CYC` cycles after entering SHUF_RUN.
- Two mid-operation cases:
  - `abort` during DEC_RUN → IDLE next cycle, owner NONE.
  - `rst` together with `start` → all outputs at reset values.

Source files
------------

// File: rtl/rc4_ctrl_pkg.sv
// Shared types and defaults for the RC4 key-search controller and phase FSMs.
package rc4_ctrl_pkg;

  localparam int                   KEY_W_DEF   = 24;
  localparam logic [KEY_W_DEF-1:0] KEY_MAX_DEF = 24'h3FFFFF;
  localparam int                   TIMEOUT_DEF = 4095;
  localparam int                   CNT_W       = 12;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_INIT_GO,
    ST_INIT_RUN,
    ST_SHUF_GO,
    ST_SHUF_RUN,
    ST_DEC_GO,
    ST_DEC_RUN,
    ST_NEXT_KEY,
    ST_DONE_OK,
    ST_DONE_EXH,
    ST_DONE_ERR
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_INIT,
    OWN_SHUF,
    OWN_DEC
  } owner_t;

  // A phase owns s_memory from its launch cycle through its run state.
  function automatic owner_t owner_of(state_t s);
    case (s)
      ST_INIT_GO, ST_INIT_RUN: owner_of = OWN_INIT;
      ST_SHUF_GO, ST_SHUF_RUN: owner_of = OWN_SHUF;
      ST_DEC_GO,  ST_DEC_RUN:  owner_of = OWN_DEC;
      default:                 owner_of = OWN_NONE;
    endcase
  endfunction

endpackage

// File: rtl/rc4_key_search_ctrl_if.sv
// Handshake and s_memory bus bundle between the controller and its phase FSMs.
interface rc4_key_search_ctrl_if #(
  parameter int KEY_W  = 24,
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              start, abort;
  logic [KEY_W-1:0]  key_start;
  logic              init_done, shuf_done, dec_done, dec_fail;
  logic              init_go, shuf_go, dec_go;
  logic [ADDR_W-1:0] init_addr, shuf_addr, dec_addr, mem_addr;
  logic [DATA_W-1:0] init_data, shuf_data, dec_data, mem_data;
  logic              init_wren, shuf_wren, dec_wren, mem_wren;
  logic [KEY_W-1:0]  key;
  logic              busy, found, exhausted, error;

  modport master (
    input  start, abort, key_start, init_done, shuf_done, dec_done, dec_fail,
           init_addr, init_data, init_wren, shuf_addr, shuf_data, shuf_wren,
           dec_addr, dec_data, dec_wren,
    output init_go, shuf_go, dec_go, mem_addr, mem_data, mem_wren,
           key, busy, found, exhausted, error
  );

  modport slave (
    output start, abort, key_start, init_done, shuf_done, dec_done, dec_fail,
           init_addr, init_data, init_wren, shuf_addr, shuf_data, shuf_wren,
           dec_addr, dec_data, dec_wren,
    input  init_go, shuf_go, dec_go, mem_addr, mem_data, mem_wren,
           key, busy, found, exhausted, error
  );
endinterface

// File: rtl/s_mem_port_mux.sv
// Single-port s_memory arbiter: the registered owner picks one requester.
module s_mem_port_mux
  import rc4_ctrl_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  owner_t            owner,
  input  logic [ADDR_W-1:0] init_addr,
  input  logic [DATA_W-1:0] init_data,
  input  logic              init_wren,
  input  logic [ADDR_W-1:0] shuf_addr,
  input  logic [DATA_W-1:0] shuf_data,
  input  logic              shuf_wren,
  input  logic [ADDR_W-1:0] dec_addr,
  input  logic [DATA_W-1:0] dec_data,
  input  logic              dec_wren,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_wren
);

  // NONE parks the port at address 0 with writes disabled.
  always_comb begin
    mem_addr = '0;
    mem_data = '0;
    mem_wren = 1'b0;
    case (owner)
      OWN_INIT: begin mem_addr = init_addr; mem_data = init_data; mem_wren = init_wren; end
      OWN_SHUF: begin mem_addr = shuf_addr; mem_data = shuf_data; mem_wren = shuf_wren; end
      OWN_DEC:  begin mem_addr = dec_addr;  mem_data = dec_data;  mem_wren = dec_wren;  end
      default:  ;
    endcase
  end

endmodule

// File: rtl/rc4_key_search_ctrl.sv
// Per-key sequencer for init/shuffle/decrypt phases and s_memory port owner.
module rc4_key_search_ctrl
  import rc4_ctrl_pkg::*;
#(
  parameter int               KEY_W       = KEY_W_DEF,
  parameter logic [KEY_W-1:0] KEY_MAX     = KEY_W'(KEY_MAX_DEF),
  parameter int               ADDR_W      = 8,
  parameter int               DATA_W      = 8,
  parameter int               TIMEOUT_CYC = TIMEOUT_DEF
) (
  input logic                   clk,
  input logic                   rst,
  rc4_key_search_ctrl_if.master bus
);

  state_t            state, state_nxt;
  owner_t            owner;
  logic [KEY_W-1:0]  key;
  logic [CNT_W-1:0]  cnt, cnt_inc;
  logic              timeout, idle_like;

  assign cnt_inc   = cnt + 1'b1;
  assign timeout   = (cnt_inc == CNT_W'(TIMEOUT_CYC));
  assign idle_like = state inside {ST_IDLE, ST_DONE_OK, ST_DONE_EXH, ST_DONE_ERR};

  // Next-state: abort dominates, done/fail only matter in the matching RUN.
  always_comb begin
    state_nxt = state;
    if (bus.abort) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE, ST_DONE_OK, ST_DONE_EXH, ST_DONE_ERR:
          if (bus.start) state_nxt = ST_INIT_GO;
        ST_INIT_GO:  state_nxt = ST_INIT_RUN;
        ST_INIT_RUN:
          if (bus.init_done)    state_nxt = ST_SHUF_GO;
          else if (timeout)     state_nxt = ST_DONE_ERR;
        ST_SHUF_GO:  state_nxt = ST_SHUF_RUN;
        ST_SHUF_RUN:
          if (bus.shuf_done)    state_nxt = ST_DEC_GO;
          else if (timeout)     state_nxt = ST_DONE_ERR;
        ST_DEC_GO:   state_nxt = ST_DEC_RUN;
        ST_DEC_RUN:
          if (bus.dec_fail)     state_nxt = ST_NEXT_KEY;
          else if (bus.dec_done) state_nxt = ST_DONE_OK;
          else if (timeout)     state_nxt = ST_DONE_ERR;
        ST_NEXT_KEY: state_nxt = (key == KEY_MAX) ? ST_DONE_EXH : ST_INIT_GO;
        default:     state_nxt = ST_IDLE;
      endcase
    end
  end

  // State, owner, key, watchdog and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      owner         <= OWN_NONE;
      key           <= '0;
      cnt           <= '0;
      bus.init_go   <= 1'b0;
      bus.shuf_go   <= 1'b0;
      bus.dec_go    <= 1'b0;
      bus.busy      <= 1'b0;
      bus.found     <= 1'b0;
      bus.exhausted <= 1'b0;
      bus.error     <= 1'b0;
    end else begin
      state         <= state_nxt;
      owner         <= owner_of(state_nxt);
      bus.init_go   <= (state_nxt == ST_INIT_GO);
      bus.shuf_go   <= (state_nxt == ST_SHUF_GO);
      bus.dec_go    <= (state_nxt == ST_DEC_GO);
      bus.busy      <= !(state_nxt inside {ST_IDLE, ST_DONE_OK, ST_DONE_EXH, ST_DONE_ERR});
      bus.found     <= (state_nxt == ST_DONE_OK);
      bus.exhausted <= (state_nxt == ST_DONE_EXH);
      bus.error     <= (state_nxt == ST_DONE_ERR);
      if (!bus.abort) begin
        if (idle_like && bus.start)
          key <= bus.key_start;
        else if (state == ST_NEXT_KEY && key != KEY_MAX)
          key <= key + 1'b1;
      end
      if (state inside {ST_INIT_GO, ST_SHUF_GO, ST_DEC_GO})
        cnt <= '0;
      else if (state inside {ST_INIT_RUN, ST_SHUF_RUN, ST_DEC_RUN})
        cnt <= cnt_inc;
    end
  end

  assign bus.key = key;

  s_mem_port_mux #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_mux (
    .owner     (owner),
    .init_addr (bus.init_addr), .init_data (bus.init_data), .init_wren (bus.init_wren),
    .shuf_addr (bus.shuf_addr), .shuf_data (bus.shuf_data), .shuf_wren (bus.shuf_wren),
    .dec_addr  (bus.dec_addr),  .dec_data  (bus.dec_data),  .dec_wren  (bus.dec_wren),
    .mem_addr  (bus.mem_addr),  .mem_data  (bus.mem_data),  .mem_wren  (bus.mem_wren)
  );

endmodule
